// File: rtl/biphase_stream_sequencer.sv
// Biphasic pulse-train timing controller for the stream selector's select_1/select_2 pair.
// Each pulse runs POS, GAP and NEG, with a REST between pulses; zero-length phases are skipped.
module biphase_stream_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pos_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] neg_len,
  input  logic [CNT_W-1:0] rest_len,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             select_1,
  output logic             select_2,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase,
  output logic [REP_W-1:0] pulses_left
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POS  = 3'd1,
    GAP  = 3'd2,
    NEG  = 3'd3,
    REST = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pos_q, pos_d, gap_q, gap_d, neg_q, neg_d, rest_q, rest_d;
  logic [REP_W-1:0] pulses_left_q, pulses_left_d;
  logic             done_q, done_d;

  function automatic logic [CNT_W-1:0] phase_len(input state_e s,
      input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] g,
      input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] r);
    case (s)
      POS:     return p;
      GAP:     return g;
      NEG:     return n;
      REST:    return r;
      default: return '0;
    endcase
  endfunction

  // Callers guarantee p or the NEG length is nonzero, so NEG is a safe fallback.
  function automatic state_e first_phase(input logic [CNT_W-1:0] p,
      input logic [CNT_W-1:0] g);
    if (p != '0)      return POS;
    else if (g != '0) return GAP;
    else              return NEG;
  endfunction

  // IDLE here means "the pulse has no further nonzero phase".
  function automatic state_e after_phase(input state_e s,
      input logic [CNT_W-1:0] g, input logic [CNT_W-1:0] n);
    case (s)
      POS:     return (g != '0) ? GAP : ((n != '0) ? NEG : IDLE);
      GAP:     return (n != '0) ? NEG : IDLE;
      default: return IDLE;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pos_d         = pos_q;
    gap_d         = gap_q;
    neg_d         = neg_q;
    rest_d        = rest_q;
    pulses_left_d = pulses_left_q;
    done_d        = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        pos_d  = pos_len;
        gap_d  = gap_len;
        neg_d  = neg_len;
        rest_d = rest_len;
        if (repeat_cnt == '0 || (pos_len == '0 && neg_len == '0)) begin
          done_d = 1'b1;
        end else begin
          state_d       = first_phase(pos_len, gap_len);
          cnt_d         = phase_len(state_d, pos_len, gap_len, neg_len, rest_len) - CNT_ONE;
          pulses_left_d = repeat_cnt - REP_ONE;
        end
      end
    end else if (abort) begin
      state_d       = IDLE;
      cnt_d         = '0;
      pulses_left_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      // Phase expiring: pick the next nonzero phase, the next pulse, or finish.
      if (state_q == REST) begin
        state_d       = first_phase(pos_q, gap_q);
        pulses_left_d = pulses_left_q - REP_ONE;
      end else if (after_phase(state_q, gap_q, neg_q) != IDLE) begin
        state_d = after_phase(state_q, gap_q, neg_q);
      end else if (pulses_left_q != '0) begin
        if (rest_q != '0) begin
          state_d = REST;
        end else begin
          state_d       = first_phase(pos_q, gap_q);
          pulses_left_d = pulses_left_q - REP_ONE;
        end
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      if (state_d != IDLE) begin
        cnt_d = phase_len(state_d, pos_q, gap_q, neg_q, rest_q) - CNT_ONE;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pos_q         <= '0;
      gap_q         <= '0;
      neg_q         <= '0;
      rest_q        <= '0;
      pulses_left_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pos_q         <= pos_d;
      gap_q         <= gap_d;
      neg_q         <= neg_d;
      rest_q        <= rest_d;
      pulses_left_q <= pulses_left_d;
      done_q        <= done_d;
    end
  end

  assign select_1    = (state_q == POS);
  assign select_2    = (state_q == NEG);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign phase       = state_q;
  assign pulses_left = pulses_left_q;

endmodule

// File: tb/tb_biphase_stream_sequencer.sv
// Directed bench for biphase_stream_sequencer: hand-built per-cycle phase/pulses_left tables.
module tb_biphase_stream_sequencer;
  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] pos_len = '0, gap_len = '0, neg_len = '0, rest_len = '0;
  logic [REP_W-1:0] repeat_cnt = '0;
  logic             select_1, select_2, busy, done;
  logic [2:0]       phase;
  logic [REP_W-1:0] pulses_left;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0]       exp_ph [0:63];
  logic [REP_W-1:0] exp_pl [0:63];
  int               exp_n;

  biphase_stream_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pos_len(pos_len), .gap_len(gap_len), .neg_len(neg_len), .rest_len(rest_len),
    .repeat_cnt(repeat_cnt),
    .select_1(select_1), .select_2(select_2), .busy(busy), .done(done),
    .phase(phase), .pulses_left(pulses_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    chk("sel_exclusive", 32'(select_1 & select_2), 0);
    chk("done_vs_busy", 32'(done & busy), 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ph, input logic [REP_W-1:0] pl, input int n);
    for (int i = 0; i < n; i++) begin
      exp_ph[exp_n] = ph;
      exp_pl[exp_n] = pl;
      exp_n++;
    end
  endtask

  // Drives start for one cycle; returns one tick after the sampling edge (cycle 1).
  task automatic launch(input int p, input int g, input int n, input int r, input int c);
    pos_len    = CNT_W'(p);
    gap_len    = CNT_W'(g);
    neg_len    = CNT_W'(n);
    rest_len   = CNT_W'(r);
    repeat_cnt = REP_W'(c);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic run_seq(input string name, input bit poke);
    for (int k = 0; k < exp_n; k++) begin
      chk($sformatf("%s_phase_c%0d", name, k + 1), 32'(phase), 32'(exp_ph[k]));
      chk($sformatf("%s_left_c%0d", name, k + 1), 32'(pulses_left), 32'(exp_pl[k]));
      chk($sformatf("%s_sel1_c%0d", name, k + 1), 32'(select_1), 32'(exp_ph[k] == 3'd1));
      chk($sformatf("%s_sel2_c%0d", name, k + 1), 32'(select_2), 32'(exp_ph[k] == 3'd3));
      chk($sformatf("%s_busy_c%0d", name, k + 1), 32'(busy), 1);
      chk($sformatf("%s_done_c%0d", name, k + 1), 32'(done), 0);
      if (poke && k == 1) begin
        start      = 1'b1;
        pos_len    = 16'd9;
        gap_len    = 16'd0;
        neg_len    = 16'd1;
        rest_len   = 16'd2;
        repeat_cnt = 8'd4;
      end
      if (poke && k == 2) start = 1'b0;
      step();
    end
    chk($sformatf("%s_end_phase", name), 32'(phase), 0);
    chk($sformatf("%s_end_busy", name), 32'(busy), 0);
    chk($sformatf("%s_end_done", name), 32'(done), 1);
    chk($sformatf("%s_end_sel", name), 32'({select_1, select_2}), 0);
    step();
    chk($sformatf("%s_after_done", name), 32'(done), 0);
    chk($sformatf("%s_after_busy", name), 32'(busy), 0);
  endtask

  task automatic build_train();
    exp_n = 0;
    push(3'd1, 8'd2, 2); push(3'd3, 8'd2, 2); push(3'd4, 8'd2, 3);
    push(3'd1, 8'd1, 2); push(3'd3, 8'd1, 2); push(3'd4, 8'd1, 3);
    push(3'd1, 8'd0, 2); push(3'd3, 8'd0, 2);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_sel1", 32'(select_1), 0);
    chk("rst_sel2", 32'(select_2), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_left", 32'(pulses_left), 0);
    rst = 1'b1;
    step();

    // Single pulse, with start and config changes injected while busy
    exp_n = 0;
    push(3'd1, 8'd0, 3); push(3'd2, 8'd0, 2); push(3'd3, 8'd0, 3);
    launch(3, 2, 3, 5, 1);
    run_seq("single", 1'b1);
    step();

    // Three-pulse train
    build_train();
    launch(2, 0, 2, 3, 3);
    run_seq("train", 1'b0);
    step();

    // Zero-length POS: one gap cycle then four NEG cycles
    exp_n = 0;
    push(3'd2, 8'd0, 1); push(3'd3, 8'd0, 4);
    launch(0, 1, 4, 0, 1);
    run_seq("zeropos", 1'b0);
    step();

    // Degenerate starts: both active phases zero, then zero repeat count
    launch(0, 3, 0, 2, 5);
    chk("degen_len_done", 32'(done), 1);
    chk("degen_len_busy", 32'(busy), 0);
    chk("degen_len_phase", 32'(phase), 0);
    step();
    chk("degen_len_done_off", 32'(done), 0);
    chk("degen_len_busy_off", 32'(busy), 0);
    launch(3, 0, 3, 0, 0);
    chk("degen_rep_done", 32'(done), 1);
    chk("degen_rep_busy", 32'(busy), 0);
    step();
    chk("degen_rep_done_off", 32'(done), 0);
    step();

    // Abort during the second pulse's NEG, then restart
    build_train();
    launch(2, 0, 2, 3, 3);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("abort_phase_c%0d", k + 1), 32'(phase), 32'(exp_ph[k]));
      if (k < 9) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_phase", 32'(phase), 0);
    chk("abort_sel", 32'({select_1, select_2}), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_left", 32'(pulses_left), 0);
    chk("abort_done", 32'(done), 0);
    step();
    chk("abort_done_next", 32'(done), 0);
    chk("abort_busy_next", 32'(busy), 0);
    launch(2, 0, 2, 3, 3);
    run_seq("restart", 1'b0);
    step();

    // Asynchronous reset mid-POS
    launch(3, 2, 3, 5, 2);
    step();
    chk("arst_pre_sel1", 32'(select_1), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_sel1", 32'(select_1), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_phase", 32'(phase), 0);
    chk("arst_left", 32'(pulses_left), 0);
    step();
    rst = 1'b1;
    step();
    chk("arst_after_phase", 32'(phase), 0);
    chk("arst_after_busy", 32'(busy), 0);
    chk("arst_after_done", 32'(done), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
